branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
Control-hazard sequencer for the ID-stage branch resolution of the 5-stage MIPS pipeline. It takes decoded branch/jump flags, operand-hazard indications and the condition result (condi_suc) from the ID-stage comparator. It stalls ID until branch operands are forwardable, then issues a registered PC redirect and squashes wrong-path instructions in IF/ID. It also keeps a saturating taken-branch counter and a sticky protocol-error flag.

Parameters:
PC_W, 32, PC/target width
STALL_MAX, 2, maximum legal consecutive operand-wait cycles
CNT_W, 16, taken counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
id_valid  in  1  instruction in ID is valid
id_beq  in  1  decoded beq
id_bne  in  1  decoded bne
id_blez  in  1  decoded blez
id_jump  in  1  decoded j/jal (register-independent)
id_pc  in  PC_W  PC of the ID instruction
id_imm  in  16  branch offset in words
id_jtarget  in  26  jump index
hz_ex  in  1  branch source written by ALU op currently in EX
hz_mem_load  in  1  branch source written by load currently in MEM
condi_suc  in  1  condition result; meaningful only when no hazard is asserted
stall_id  out  1  hold PC and IF/ID (combinational)
flush_if  out  1  squash IF/ID contents (registered)
flush_id  out  1  squash ID/EX contents (registered)
pc_redirect  out  1  load pc_target into PC (registered)
pc_target  out  PC_W  redirect address (registered)
busy  out  1  state != IDLE
hz_err  out  1  sticky protocol error
taken_cnt  out  CNT_W  saturating taken count

Behaviour:
- Reset (async, any state): state=IDLE, wait_cnt=0. All registered outputs are 0, including pc_target, hz_err and taken_cnt.
- is_br = id_beq|id_bne|id_blez. hz = hz_ex|hz_mem_load.
- Branch target: id_pc + 4 + (sign_ext(id_imm) << 2), modulo 2^PC_W (wraps silently).
- Jump target: {(id_pc+4)[31:28], id_jtarget, 2'b00}.
- IDLE:
  - id_valid & id_jump: taken without a hazard check. Latch the jump target, go to REDIR.
  - id_valid & is_br & hz: stall_id=1, wait_cnt=1, go to WAIT.
  - id_valid & is_br & !hz: resolve this cycle. If condi_suc, latch the branch target and go to REDIR; otherwise stay IDLE with no outputs asserted.
- WAIT: stall_id = hz.
  - !id_valid: abort (upstream flush), go to IDLE, no redirect.
  - hz: stay, wait_cnt++ (saturating). If wait_cnt ≥ STALL_MAX while hz is still high, set hz_err and keep waiting.
  - !hz: resolve exactly as in IDLE, using condi_suc in this cycle.
- REDIR (exactly 1 cycle): pc_redirect=flush_if=flush_id=1, pc_target valid, taken_cnt++ saturating at all-ones. ID inputs are ignored (that instruction is being squashed). Next state IDLE.
- Taken penalty is 2 wrong-path slots (ID and IF in the REDIR cycle). Not-taken penalty is 0 beyond the hazard stall.
- id_jump together with is_br, or more than one of beq/bne/blez set: set hz_err. Jump has priority; otherwise resolve with condi_suc.
- pc_target holds its value outside REDIR. Only pc_redirect qualifies it.
- hz_err clears only on reset.

Test Plan:
1. IDLE, beq, no hazard, condi_suc=1, id_pc=0x0040_0010, id_imm=0x0003 → next cycle pc_redirect=flush_if=flush_id=1 for exactly 1 cycle, pc_target=0x0040_0020, taken_cnt 0→1, stall_id never high.
2. bne, no hazard, condi_suc=0 → no redirect, no flush, stall_id=0, busy=0, taken_cnt unchanged.
3. blez with hz_ex=1 (cycle 0), hz_mem_load=1 (cycle 1), both low (cycle 2), condi_suc=1 at cycle 2 only, id_pc=0, id_imm=0xFFFF → stall_id high cycles 0–1, redirect at cycle 3 with pc_target=0x0000_0000, hz_err=0. Repeat with condi_suc=1 only in cycle 1 → no redirect.
4. j with hz_ex=1, id_pc=0x8000_0000, id_jtarget=0x0000100 → stall_id=0, next cycle pc_target=0x8000_0400; then id_pc=0xFFFF_FFF8, beq, id_imm=1, taken → pc_target=0x0000_0000 (wrap).
5. STALL_MAX=2, hz held 3 cycles → hz_err=1 and stays set after the branch resolves; assert rst_n=0 mid-WAIT → immediate IDLE, all outputs 0, hz_err=0, taken_cnt=0.
6. WAIT with id_valid dropped → IDLE next cycle, no redirect. CNT_W=2, 4 taken branches → taken_cnt saturates at 3.

Source files
------------

// File: rtl/branch_ctrl.sv
//============================================================================
// Module      : branch_ctrl
// Description : ID-stage control-hazard sequencer. Holds ID while branch
//               operands are still in flight, then issues a one-cycle
//               registered PC redirect that squashes IF/ID and ID/EX.
//               Also counts taken redirects and keeps a sticky error flag.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module branch_ctrl #(
  parameter int PC_W      = 32,
  parameter int STALL_MAX = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_beq,
  input  logic              id_bne,
  input  logic              id_blez,
  input  logic              id_jump,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [15:0]       id_imm,
  input  logic [25:0]       id_jtarget,
  input  logic              hz_ex,
  input  logic              hz_mem_load,
  input  logic              condi_suc,
  output logic              stall_id,
  output logic              flush_if,
  output logic              flush_id,
  output logic              pc_redirect,
  output logic [PC_W-1:0]   pc_target,
  output logic              busy,
  output logic              hz_err,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_REDIR = 2'd2;

  // One spare bit so the counter can pass STALL_MAX before saturating.
  localparam int                  c_WAIT_W    = $clog2(STALL_MAX + 1) + 1;
  localparam logic [c_WAIT_W-1:0] c_STALL_MAX = c_WAIT_W'(STALL_MAX);
  localparam logic [c_WAIT_W-1:0] c_WAIT_SAT  = '1;
  localparam logic [CNT_W-1:0]    c_CNT_SAT   = '1;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_redir;
  logic [PC_W-1:0]     r_target;
  logic                r_hz_err;
  logic [CNT_W-1:0]    r_taken_cnt;

  logic                w_is_br;
  logic                w_hz;
  logic                w_multi_br;
  logic                w_bad_decode;
  logic                w_wait_overrun;
  logic [PC_W-1:0]     w_pc4;
  logic [PC_W-1:0]     w_br_tgt;
  logic [PC_W-1:0]     w_j_tgt;
  logic [PC_W-1:0]     w_res_tgt;
  logic                w_res_take;
  logic                w_stall;
  logic                w_load;

  assign w_is_br    = id_beq | id_bne | id_blez;
  assign w_hz       = hz_ex | hz_mem_load;
  assign w_multi_br = (id_beq & id_bne) | (id_beq & id_blez) | (id_bne & id_blez);

  // Squashed instructions in REDIR are not checked for malformed decode.
  assign w_bad_decode = id_valid & (r_state != c_REDIR) &
                        ((id_jump & w_is_br) | w_multi_br);

  assign w_wait_overrun = (r_state == c_WAIT) & id_valid & w_hz &
                          (r_wait_cnt >= c_STALL_MAX);

  // Both targets wrap modulo 2^PC_W; the branch offset is in words.
  assign w_pc4    = id_pc + PC_W'(4);
  assign w_br_tgt = w_pc4 + {{(PC_W-18){id_imm[15]}}, id_imm, 2'b00};
  assign w_j_tgt  = {w_pc4[PC_W-1:28], id_jtarget, 2'b00};

  // Jump wins over any branch flag; otherwise the comparator decides.
  assign w_res_take = id_jump | condi_suc;
  assign w_res_tgt  = id_jump ? w_j_tgt : w_br_tgt;

  // Next-state, stall and target-load decode.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (id_valid && id_jump) begin
          w_load = 1'b1;
          w_next = c_REDIR;
        end else if (id_valid && w_is_br) begin
          if (w_hz) begin
            w_stall = 1'b1;
            w_next  = c_WAIT;
          end else if (condi_suc) begin
            w_load = 1'b1;
            w_next = c_REDIR;
          end
        end
      end
      c_WAIT: begin
        w_stall = w_hz;
        if (!id_valid) begin
          w_next = c_IDLE;
        end else if (!w_hz) begin
          if (w_res_take) begin
            w_load = 1'b1;
            w_next = c_REDIR;
          end else begin
            w_next = c_IDLE;
          end
        end
      end
      c_REDIR: w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // State register and operand-wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == c_IDLE && w_next == c_WAIT) begin
        r_wait_cnt <= c_WAIT_W'(1);
      end else if (r_state == c_WAIT && w_next == c_WAIT) begin
        if (r_wait_cnt != c_WAIT_SAT) begin
          r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // Redirect pulse and target latch; the target holds outside REDIR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redir  <= 1'b0;
      r_target <= '0;
    end else begin
      r_redir <= w_load;
      if (w_load) begin
        r_target <= (r_state == c_IDLE && id_jump) ? w_j_tgt : w_res_tgt;
      end
    end
  end

  // Sticky protocol error: wait overrun or malformed decode flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hz_err <= 1'b0;
    end else if (w_bad_decode || w_wait_overrun) begin
      r_hz_err <= 1'b1;
    end
  end

  // Saturating count of completed redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt <= '0;
    end else if (r_state == c_REDIR && r_taken_cnt != c_CNT_SAT) begin
      r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign stall_id    = w_stall;
  assign pc_redirect = r_redir;
  assign flush_if    = r_redir;
  assign flush_id    = r_redir;
  assign pc_target   = r_target;
  assign busy        = (r_state != c_IDLE);
  assign hz_err      = r_hz_err;
  assign taken_cnt   = r_taken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
//============================================================================
// Module      : tb_branch_ctrl
// Description : Self-checking bench for branch_ctrl. Expected redirect
//               targets go into a queue when a taken branch/jump is driven
//               and are popped when the DUT raises pc_redirect. A second
//               instance with CNT_W=2 shares the stimulus for saturation.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_beq, id_bne, id_blez, id_jump;
  logic [31:0] id_pc;
  logic [15:0] id_imm;
  logic [25:0] id_jtarget;
  logic        hz_ex, hz_mem_load, condi_suc;

  logic        stall_id, flush_if, flush_id, pc_redirect, busy, hz_err;
  logic [31:0] pc_target;
  logic [15:0] taken_cnt;

  logic        stall_id_b, flush_if_b, flush_id_b, pc_redirect_b, busy_b, hz_err_b;
  logic [31:0] pc_target_b;
  logic [1:0]  taken_cnt_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt   = '0;
  logic [1:0]  exp_cnt_b = '0;

  always #5 clk = ~clk;

  branch_ctrl #(.PC_W(32), .STALL_MAX(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_beq(id_beq),
    .id_bne(id_bne), .id_blez(id_blez), .id_jump(id_jump), .id_pc(id_pc),
    .id_imm(id_imm), .id_jtarget(id_jtarget), .hz_ex(hz_ex),
    .hz_mem_load(hz_mem_load), .condi_suc(condi_suc), .stall_id(stall_id),
    .flush_if(flush_if), .flush_id(flush_id), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .busy(busy), .hz_err(hz_err), .taken_cnt(taken_cnt)
  );

  branch_ctrl #(.PC_W(32), .STALL_MAX(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_beq(id_beq),
    .id_bne(id_bne), .id_blez(id_blez), .id_jump(id_jump), .id_pc(id_pc),
    .id_imm(id_imm), .id_jtarget(id_jtarget), .hz_ex(hz_ex),
    .hz_mem_load(hz_mem_load), .condi_suc(condi_suc), .stall_id(stall_id_b),
    .flush_if(flush_if_b), .flush_id(flush_id_b), .pc_redirect(pc_redirect_b),
    .pc_target(pc_target_b), .busy(busy_b), .hz_err(hz_err_b), .taken_cnt(taken_cnt_b)
  );

  // Scoreboard: every redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pc_redirect === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_redirect: got target %h, none expected", pc_target);
      end else begin
        logic [31:0] t;
        t = exp_q.pop_front();
        if (pc_target !== t || flush_if !== 1'b1 || flush_id !== 1'b1) begin
          n_fail++;
          $display("FAIL redirect_target: got %h fi=%b fd=%b, expected %h fi=1 fd=1",
                   pc_target, flush_if, flush_id, t);
        end
      end
    end
  end

  task automatic set_in(input logic v, input logic b, input logic n, input logic z,
                        input logic j, input logic [31:0] pc, input logic [15:0] imm,
                        input logic [25:0] jt, input logic hx, input logic hm,
                        input logic cs);
    id_valid = v; id_beq = b; id_bne = n; id_blez = z; id_jump = j;
    id_pc = pc; id_imm = imm; id_jtarget = jt;
    hz_ex = hx; hz_mem_load = hm; condi_suc = cs;
  endtask

  task automatic clear_in();
    set_in(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 0, 0, 0);
  endtask

  task automatic expect_taken(input logic [31:0] t);
    exp_q.push_back(t);
    exp_cnt++;
    if (exp_cnt_b != 2'd3) exp_cnt_b++;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({pc_redirect, flush_if, flush_id, busy, hz_err, stall_id} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 000000",
               {pc_redirect, flush_if, flush_id, busy, hz_err, stall_id});
    end
    n_checks++;
    if (pc_target !== 32'h0 || taken_cnt !== 16'h0 || taken_cnt_b !== 2'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got tgt=%h cnt=%h cnt_b=%h, expected 0",
               pc_target, taken_cnt, taken_cnt_b);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_taken_beq();
    @(negedge clk);
    set_in(1, 1, 0, 0, 0, 32'h0040_0010, 16'h0003, 26'h0, 0, 0, 1);
    expect_taken(32'h0040_0020);
    #1;
    n_checks++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL beq_stall: got %b, expected 0", stall_id);
    end
    @(negedge clk); clear_in();
    n_checks++;
    if (pc_redirect !== 1'b1 || taken_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL beq_redir: got redir=%b cnt=%0d, expected redir=1 cnt=0",
               pc_redirect, taken_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (pc_redirect !== 1'b0 || busy !== 1'b0 || taken_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL beq_after: got redir=%b busy=%b cnt=%0d, expected 0 0 1",
               pc_redirect, busy, taken_cnt);
    end
  endtask

  task automatic test_not_taken();
    @(negedge clk);
    set_in(1, 0, 1, 0, 0, 32'h0000_1000, 16'h0010, 26'h0, 0, 0, 0);
    #1;
    n_checks++;
    if (stall_id !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bne_nt_comb: got stall=%b busy=%b, expected 0 0", stall_id, busy);
    end
    @(negedge clk); clear_in();
    n_checks++;
    if (pc_redirect !== 1'b0 || flush_if !== 1'b0 || busy !== 1'b0 || taken_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL bne_nt: got redir=%b fi=%b busy=%b cnt=%0d, expected 0 0 0 %0d",
               pc_redirect, flush_if, busy, taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_hazard_wait();
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      set_in(1, 0, 0, 1, 0, 32'h0, 16'hFFFF, 26'h0, 1, 0, 0);
      #1;
      n_checks++;
      if (stall_id !== 1'b1) begin
        n_fail++; $display("FAIL blez_stall0: got %b, expected 1", stall_id);
      end
      @(negedge clk);
      set_in(1, 0, 0, 1, 0, 32'h0, 16'hFFFF, 26'h0, 0, 1, rep == 1);
      #1;
      n_checks++;
      if (stall_id !== 1'b1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL blez_stall1: got stall=%b busy=%b, expected 1 1", stall_id, busy);
      end
      @(negedge clk);
      set_in(1, 0, 0, 1, 0, 32'h0, 16'hFFFF, 26'h0, 0, 0, rep == 0);
      if (rep == 0) expect_taken(32'h0);
      #1;
      n_checks++;
      if (stall_id !== 1'b0) begin
        n_fail++; $display("FAIL blez_stall2: got %b, expected 0", stall_id);
      end
      @(negedge clk); clear_in();
      n_checks++;
      if (pc_redirect !== (rep == 0) || hz_err !== 1'b0) begin
        n_fail++;
        $display("FAIL blez_resolve%0d: got redir=%b err=%b, expected redir=%b err=0",
                 rep, pc_redirect, hz_err, rep == 0);
      end
      @(negedge clk);
    end
    n_checks++;
    if (taken_cnt !== exp_cnt || busy !== 1'b0) begin
      n_fail++; $display("FAIL blez_cnt: got cnt=%0d busy=%b, expected %0d 0", taken_cnt, busy, exp_cnt);
    end
  endtask

  task automatic test_jump_wrap();
    @(negedge clk);
    set_in(1, 0, 0, 0, 1, 32'h8000_0000, 16'h0, 26'h000_0100, 1, 0, 0);
    expect_taken(32'h8000_0400);
    #1;
    n_checks++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL jump_stall: got %b, expected 0", stall_id);
    end
    @(negedge clk); clear_in();
    n_checks++;
    if (pc_redirect !== 1'b1) begin
      n_fail++; $display("FAIL jump_redir: got %b, expected 1", pc_redirect);
    end
    @(negedge clk);
    set_in(1, 1, 0, 0, 0, 32'hFFFF_FFF8, 16'h0001, 26'h0, 0, 0, 1);
    expect_taken(32'h0000_0000);
    @(negedge clk); clear_in();
    n_checks++;
    if (pc_redirect !== 1'b1) begin
      n_fail++; $display("FAIL wrap_redir: got %b, expected 1", pc_redirect);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_in(1, 1, 0, 0, 0, 32'h0000_1000, 16'h0002, 26'h0, 0, 0, 1);
    expect_taken(32'h0000_100C);
    @(negedge clk);
    // REDIR cycle: this taken branch is wrong-path and must be ignored.
    set_in(1, 1, 0, 0, 0, 32'h0000_2000, 16'h0000, 26'h0, 1, 0, 1);
    #1;
    n_checks++;
    if (stall_id !== 1'b0 || pc_redirect !== 1'b1) begin
      n_fail++; $display("FAIL b2b_redir: got stall=%b redir=%b, expected 0 1", stall_id, pc_redirect);
    end
    @(negedge clk);
    set_in(1, 1, 0, 0, 0, 32'h0000_3000, 16'h0001, 26'h0, 0, 0, 1);
    expect_taken(32'h0000_3008);
    n_checks++;
    if (pc_redirect !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ignored: got redir=%b busy=%b, expected 0 0", pc_redirect, busy);
    end
    @(negedge clk); clear_in();
    @(negedge clk);
    n_checks++;
    if (taken_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL b2b_cnt: got %0d, expected %0d", taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall_max();
    @(negedge clk);
    set_in(1, 1, 0, 0, 0, 32'h0000_0100, 16'h0004, 26'h0, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (hz_err !== 1'b0) begin
      n_fail++; $display("FAIL stall2_err: got %b, expected 0", hz_err);
    end
    @(negedge clk);
    n_checks++;
    if (hz_err !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall3_err: got err=%b busy=%b, expected 1 1", hz_err, busy);
    end
    set_in(1, 1, 0, 0, 0, 32'h0000_0100, 16'h0004, 26'h0, 0, 0, 1);
    expect_taken(32'h0000_0114);
    @(negedge clk); clear_in();
    @(negedge clk);
    n_checks++;
    if (hz_err !== 1'b1 || busy !== 1'b0 || taken_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b busy=%b cnt=%0d, expected 1 0 %0d",
               hz_err, busy, taken_cnt, exp_cnt);
    end
    // Reset arrives in the middle of a WAIT cycle, away from any clock edge.
    set_in(1, 1, 0, 0, 0, 32'h0000_0200, 16'h0001, 26'h0, 1, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_in();
    exp_cnt = '0;
    exp_cnt_b = '0;
    #1;
    n_checks++;
    if ({pc_redirect, flush_if, flush_id, busy, hz_err, stall_id} !== 6'b0 ||
        taken_cnt !== 16'h0 || taken_cnt_b !== 2'h0 || pc_target !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got flags=%b cnt=%0d cnt_b=%0d tgt=%h, expected all 0",
               {pc_redirect, flush_if, flush_id, busy, hz_err, stall_id},
               taken_cnt, taken_cnt_b, pc_target);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    @(negedge clk);
    set_in(1, 1, 0, 0, 0, 32'h0000_0300, 16'h0002, 26'h0, 0, 1, 1);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_wait: got busy=%b, expected 1", busy);
    end
    set_in(0, 1, 0, 0, 0, 32'h0000_0300, 16'h0002, 26'h0, 0, 0, 1);
    @(negedge clk); clear_in();
    n_checks++;
    if (busy !== 1'b0 || pc_redirect !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b redir=%b, expected 0 0", busy, pc_redirect);
    end
    @(negedge clk);
    n_checks++;
    if (pc_redirect !== 1'b0 || taken_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL abort_noredir: got redir=%b cnt=%0d, expected 0 %0d",
                         pc_redirect, taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pc;
      pc = 32'h0000_4000 + 32'(i * 16);
      @(negedge clk);
      set_in(1, 1, 0, 0, 0, pc, 16'(i), 26'h0, 0, 0, 1);
      expect_taken(pc + 32'h4 + 32'(i * 4));
      @(negedge clk); clear_in();
    end
    @(negedge clk);
    n_checks++;
    if (taken_cnt_b !== 2'd3 || taken_cnt_b !== exp_cnt_b || taken_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL cnt_saturate: got cnt_b=%0d cnt=%0d, expected cnt_b=3 cnt=%0d",
               taken_cnt_b, taken_cnt, exp_cnt);
    end
  endtask

  task automatic test_decode_err();
    n_checks++;
    if (hz_err !== 1'b0) begin
      n_fail++; $display("FAIL pre_decode_err: got %b, expected 0", hz_err);
    end
    @(negedge clk);
    set_in(1, 1, 1, 0, 0, 32'h0000_0500, 16'h0000, 26'h0, 0, 0, 1);
    expect_taken(32'h0000_0504);
    @(negedge clk); clear_in();
    n_checks++;
    if (pc_redirect !== 1'b1 || hz_err !== 1'b1) begin
      n_fail++; $display("FAIL multi_br: got redir=%b err=%b, expected 1 1", pc_redirect, hz_err);
    end
    @(negedge clk);
    set_in(1, 1, 0, 0, 1, 32'h0000_0600, 16'h0008, 26'h000_0040, 1, 0, 0);
    expect_taken(32'h0000_0100);
    #1;
    n_checks++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL jump_prio_stall: got %b, expected 0", stall_id);
    end
    @(negedge clk); clear_in();
    n_checks++;
    if (pc_redirect !== 1'b1) begin
      n_fail++; $display("FAIL jump_prio: got redir=%b, expected 1", pc_redirect);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    repeat (2) @(negedge clk);
    test_reset();
    test_taken_beq();
    test_not_taken();
    test_hazard_wait();
    test_jump_wrap();
    test_back_to_back();
    test_stall_max();
    test_abort();
    test_saturate();
    test_decode_err();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_redirect: %0d expected redirects never seen", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
